// File: rtl/dbg_pkg.sv
// dbg_pkg: shared seven-segment encoding for the debug display unit.
package dbg_pkg;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    return SEG_LUT[h];
  endfunction
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: accepts a level change after DEBOUNCE stable cycles, pulses rise on 0->1.
module btn_debounce #(
  parameter int DEBOUNCE = 250_000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise
);
  localparam int CW = $clog2(DEBOUNCE + 1);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk)
    if (rst) begin
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
    end else begin
      rise <= 1'b0;
      if (raw == level) cnt <= '0;
      else if (cnt == CW'(DEBOUNCE - 1)) begin
        cnt   <= '0;
        level <= raw;
        rise  <= raw;
      end else cnt <= cnt + CW'(1);
    end
endmodule

// File: rtl/dbg_display_unit.sv
// dbg_display_unit: button-driven address browse, run/step control and multiplexed hex display.
module dbg_display_unit import dbg_pkg::*; #(
  parameter int N_DIGITS      = 8,
  parameter int N_SRC         = 4,
  parameter int ADDR_W        = 8,
  parameter int DEBOUNCE      = 250_000,
  parameter int SCAN_DIV      = 8192,
  parameter int REPEAT_DELAY  = 50_000_000,
  parameter int REPEAT_PERIOD = 10_000_000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          btn_inc,
  input  logic                          btn_dec,
  input  logic                          btn_step,
  input  logic                          btn_run,
  input  logic [ADDR_W-1:0]             init_addr,
  input  logic [$clog2(N_SRC)-1:0]      src_sel,
  input  logic [N_SRC*4*N_DIGITS-1:0]   src_data,
  input  logic                          blank_lz,
  output logic [ADDR_W-1:0]             addr,
  output logic                          run,
  output logic                          step_pulse,
  output logic [N_DIGITS-1:0]           an,
  output logic [6:0]                    seg,
  output logic                          dp
);
  localparam int DATA_W = 4 * N_DIGITS;
  localparam int SEL_W  = $clog2(N_SRC);
  localparam int HW     = $clog2(REPEAT_DELAY + REPEAT_PERIOD + 1);
  localparam int SCW    = $clog2(SCAN_DIV + 1);
  localparam int IW     = $clog2(N_DIGITS + 1);

  logic inc_lvl, dec_lvl, step_lvl, run_lvl;
  logic inc_rise, dec_rise, step_rise, run_rise;
  logic unused_lvl;
  assign unused_lvl = step_lvl ^ run_lvl;

  btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_inc  (.clk(clk), .rst(rst), .raw(btn_inc),  .level(inc_lvl),  .rise(inc_rise));
  btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_dec  (.clk(clk), .rst(rst), .raw(btn_dec),  .level(dec_lvl),  .rise(dec_rise));
  btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_step (.clk(clk), .rst(rst), .raw(btn_step), .level(step_lvl), .rise(step_rise));
  btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_run  (.clk(clk), .rst(rst), .raw(btn_run),  .level(run_lvl),  .rise(run_rise));

  logic [HW-1:0]     hcnt;
  logic              armed, rep;
  logic              one, hit;
  logic [ADDR_W-1:0] addr_nx;
  assign one     = inc_lvl ^ dec_lvl;
  assign addr_nx = inc_lvl ? addr + ADDR_W'(1) : addr - ADDR_W'(1);
  assign hit     = hcnt == (rep ? HW'(REPEAT_PERIOD - 1) : HW'(REPEAT_DELAY - 1));

  // armed is only set by a fresh rise, so releasing one of two held buttons never steps
  always_ff @(posedge clk)
    if (rst) begin
      addr  <= init_addr;
      armed <= 1'b0;
      rep   <= 1'b0;
      hcnt  <= '0;
    end else if ((inc_rise | dec_rise) & one) begin
      addr  <= addr_nx;
      armed <= 1'b1;
      rep   <= 1'b0;
      hcnt  <= '0;
    end else if (!one || !armed) begin
      armed <= 1'b0;
      rep   <= 1'b0;
      hcnt  <= '0;
    end else if (hit) begin
      addr <= addr_nx;
      rep  <= 1'b1;
      hcnt <= '0;
    end else hcnt <= hcnt + HW'(1);

  always_ff @(posedge clk)
    if (rst) begin
      run        <= 1'b0;
      step_pulse <= 1'b0;
    end else begin
      run        <= run ^ run_rise;
      step_pulse <= step_rise & ~run;
    end

  logic [SCW-1:0]    scnt;
  logic [IW-1:0]     idx, msd;
  logic [DATA_W-1:0] snap, sel_data;
  logic [3:0]        nib;
  logic              last_s;
  assign last_s = scnt == SCW'(SCAN_DIV - 1);
  assign nib    = 4'(snap >> {idx, 2'b00});

  always_comb begin
    sel_data = '0;
    for (int k = 0; k < N_SRC; k++)
      if (src_sel == SEL_W'(k)) sel_data = src_data[k*DATA_W +: DATA_W];
  end

  always_comb begin
    msd = '0;
    for (int i = 1; i < N_DIGITS; i++)
      if (snap[i*4 +: 4] != 4'h0) msd = IW'(i);
  end

  // snapshot only at the start of a scan so a frame never mixes two values
  always_ff @(posedge clk)
    if (rst) begin
      scnt <= '0;
      idx  <= '0;
      snap <= '0;
      an   <= '1;
      seg  <= SEG_BLANK;
      dp   <= 1'b1;
    end else begin
      scnt <= last_s ? '0 : scnt + SCW'(1);
      if (last_s) idx <= (idx == IW'(N_DIGITS - 1)) ? '0 : idx + IW'(1);
      if (idx == '0 && scnt == '0) snap <= sel_data;
      an  <= ~(N_DIGITS'(1) << idx);
      seg <= (blank_lz && idx > msd) ? SEG_BLANK : hex_to_seg(nib);
      dp  <= ~(idx == '0 && run);
    end
endmodule

// File: tb/tb_dbg_display_unit.sv
// tb_dbg_display_unit: directed checks of button stepping, run/step control and display scan.
module tb_dbg_display_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  btn = 4'b0;
  logic [3:0]  init_addr = 4'hE;
  logic [1:0]  src_sel = 2'd1;
  logic [47:0] src_data = {16'h2222, 16'h00A3, 16'h1111};
  logic        blank_lz = 1'b0;
  logic [3:0]  addr;
  logic        run, step_pulse, dp;
  logic [3:0]  an;
  logic [6:0]  seg;
  int n_vec = 0, n_err = 0, n_pulse = 0;

  dbg_display_unit #(
    .N_DIGITS(4), .N_SRC(3), .ADDR_W(4), .DEBOUNCE(4),
    .SCAN_DIV(4), .REPEAT_DELAY(20), .REPEAT_PERIOD(5)
  ) dut (
    .clk(clk), .rst(rst),
    .btn_inc(btn[0]), .btn_dec(btn[1]), .btn_step(btn[2]), .btn_run(btn[3]),
    .init_addr(init_addr), .src_sel(src_sel), .src_data(src_data), .blank_lz(blank_lz),
    .addr(addr), .run(run), .step_pulse(step_pulse), .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (step_pulse) n_pulse++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [3:0] m, input int n);
    btn = m;
    tick(n);
    btn = 4'b0;
    tick(8);
  endtask

  // returns on the second cycle of digit d, past the cycle where a new snapshot lands
  task automatic wait_digit(input int d);
    logic [3:0] want;
    bit hit, prev;
    want = ~(4'b1 << d);
    hit  = 1'b0;
    prev = (an == want);
    for (int t = 0; t < 60 && !hit; t++) begin
      @(negedge clk);
      hit  = (an == want) && !prev;
      prev = (an == want);
    end
    if (!hit) chk("digit_timeout", 32'(d), 32'hFFFF);
    @(negedge clk);
  endtask

  int p0;
  initial begin
    tick(2);
    chk("rst_addr", addr, 4'hE);
    chk("rst_run", run, 0);
    chk("rst_step", step_pulse, 0);
    chk("rst_an", an, 4'hF);
    chk("rst_seg", seg, 7'h7F);
    chk("rst_dp", dp, 1);
    rst = 1'b0;
    tick(2);
    chk("d0_an_first", an, 4'b1110);
    chk("d0_seg_first", seg, 7'h30);
    wait_digit(1); chk("d1_seg", seg, 7'h08); chk("d1_an", an, 4'b1101);
    wait_digit(2); chk("d2_seg", seg, 7'h40); chk("d2_an", an, 4'b1011);
    wait_digit(3); chk("d3_seg", seg, 7'h40); chk("d3_an", an, 4'b0111);
    wait_digit(0); chk("d0_seg", seg, 7'h30); chk("d0_dp_run0", dp, 1);

    press(4'b0001, 6); chk("inc_E_F", addr, 4'hF);
    press(4'b0001, 6); chk("inc_wrap", addr, 4'h0);
    press(4'b0001, 3); chk("glitch", addr, 4'h0);
    press(4'b0010, 6); chk("dec_wrap", addr, 4'hF);
    press(4'b0001, 6); chk("inc_back", addr, 4'h0);

    btn = 4'b0001;
    tick(5);  chk("rep_rise", addr, 4'h1);
    tick(19); chk("rep_pre_delay", addr, 4'h1);
    tick(1);  chk("rep_first", addr, 4'h2);
    tick(4);  chk("rep_pre_period", addr, 4'h2);
    tick(1);  chk("rep_second", addr, 4'h3);
    tick(10); chk("rep_fourth", addr, 4'h5);
    btn = 4'b0;
    tick(10); chk("rep_total", addr, 4'h5);

    btn = 4'b0011;
    tick(40); chk("both_frozen", addr, 4'h5);
    btn = 4'b0001;
    tick(30); chk("release_one", addr, 4'h5);
    btn = 4'b0;
    tick(8);

    p0 = n_pulse;
    press(4'b0100, 6); chk("step_once", n_pulse - p0, 1);
    press(4'b1000, 6); chk("run_on", run, 1);
    p0 = n_pulse;
    press(4'b0100, 6); chk("step_ignored", n_pulse - p0, 0);
    press(4'b1000, 6); chk("run_off", run, 0);
    p0 = n_pulse;
    press(4'b1100, 6);
    chk("both_run", run, 1);
    chk("both_step", n_pulse - p0, 1);

    wait_digit(0); chk("dp_run", dp, 0);
    wait_digit(1); chk("dp_d1", dp, 1);

    blank_lz = 1'b1;
    wait_digit(2); chk("blank_d2", seg, 7'h7F); chk("blank_d2_an", an, 4'b1011);
    wait_digit(3); chk("blank_d3", seg, 7'h7F);
    wait_digit(0); chk("blank_d0", seg, 7'h30);
    wait_digit(1); chk("blank_d1", seg, 7'h08);
    blank_lz = 1'b0;

    src_data[31:16] = 16'h5B7C;
    wait_digit(2); chk("tear_d2", seg, 7'h40);
    wait_digit(3); chk("tear_d3", seg, 7'h40);
    wait_digit(0); chk("new_d0", seg, 7'h46);
    wait_digit(1); chk("new_d1", seg, 7'h78);
    wait_digit(2); chk("new_d2", seg, 7'h03);
    wait_digit(3); chk("new_d3", seg, 7'h12);

    src_sel = 2'd3;
    wait_digit(3);
    wait_digit(0); chk("sel3_d0", seg, 7'h40);
    wait_digit(1); chk("sel3_d1", seg, 7'h40);
    wait_digit(2); chk("sel3_d2", seg, 7'h40);
    wait_digit(3); chk("sel3_d3", seg, 7'h40);
    blank_lz = 1'b1;
    wait_digit(0); chk("zero_d0", seg, 7'h40);
    wait_digit(3); chk("zero_d3", seg, 7'h7F);

    btn = 4'b0001;
    tick(30);
    rst = 1'b1;
    tick(1);
    chk("mid_an", an, 4'hF);
    chk("mid_seg", seg, 7'h7F);
    chk("mid_dp", dp, 1);
    chk("mid_addr", addr, 4'hE);
    chk("mid_run", run, 0);
    rst = 1'b0;
    tick(6); chk("held_restep", addr, 4'hF);
    btn = 4'b0;
    tick(8); chk("held_once", addr, 4'hF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
